panel_seq: RTL and testbench

//  Parametrised front-panel sequencer: the successor to the fixed-width panel FSM in system.

---
 rtl/panel_seq.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_panel_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_seq.sv
// Front-panel sequencer: turns panel buttons into core control, LOAD/LOOK memory
// accesses, N-step execution and address breakpoints.
module panel_seq #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned NUM_BKPT = 2,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       btn_addr_i,
  input  logic                       btn_load_i,
  input  logic                       btn_look_i,
  input  logic                       btn_step_i,
  input  logic                       btn_run_i,
  input  logic                       btn_stop_i,
  input  logic                       btn_enter_i,
  output logic                       btn_addr_o,
  output logic                       btn_load_o,
  output logic                       btn_look_o,
  output logic                       btn_step_o,
  output logic                       btn_run_o,
  output logic                       btn_stop_o,
  output logic                       btn_enter_o,
  output logic                       led_ready_o,
  output logic                       led_inwait_o,
  output logic                       led_halt_o,
  output logic                       led_bkpt_o,
  input  logic [ADDR_W-1:0]          sw_addr_i,
  input  logic [DATA_W-1:0]          sw_data_i,
  input  logic [CNT_W-1:0]           step_cnt_i,
  input  logic [NUM_BKPT-1:0]        bkpt_en_i,
  input  logic [NUM_BKPT*ADDR_W-1:0] bkpt_addr_i,
  output logic                       core_rst_no,
  output logic                       cpu_exec_o,
  output logic                       pc_wen_o,
  output logic [ADDR_W-1:0]          pc_o,
  input  logic [ADDR_W-1:0]          core_pc_i,
  input  logic                       core_idle_i,
  input  logic                       core_halt_i,
  input  logic                       core_inwait_i,
  input  logic                       instr_val_i,
  input  logic [DATA_W-1:0]          instr_data_i,
  output logic                       mem_sel_o,
  output logic                       mem_val_o,
  output logic                       mem_wen_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W-1:0]          mem_wdata_o,
  input  logic [DATA_W-1:0]          mem_rdata_i,
  input  logic                       mem_rdy_i,
  output logic [DATA_W-1:0]          disp_data_o
);

  localparam int unsigned NBTN    = 7;
  localparam int unsigned B_ADDR  = 0;
  localparam int unsigned B_LOAD  = 1;
  localparam int unsigned B_LOOK  = 2;
  localparam int unsigned B_STEP  = 3;
  localparam int unsigned B_RUN   = 4;
  localparam int unsigned B_STOP  = 5;
  localparam int unsigned B_ENTER = 6;

  localparam logic [NBTN-1:0] LAMP_READY  = 7'b0011111;
  localparam logic [NBTN-1:0] LAMP_RUN    = 7'b0100000;
  localparam logic [NBTN-1:0] LAMP_INWAIT = 7'b1000110;

  typedef enum logic [2:0] {
    S_READY, S_ADDR, S_MEM, S_RUN, S_STEP, S_DRAIN, S_INWAIT
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d, cnt_eff;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   disp_q, disp_d;
  logic                ret_inwait_q, ret_inwait_d;
  logic                is_load_q, is_load_d;
  logic                led_halt_q, led_halt_d;
  logic                led_bkpt_q, led_bkpt_d;
  logic [NBTN-1:0]     btn_raw, btn_prev_q, btn_edge_q, go;
  logic [NBTN-1:0]     lamp_q, lamp_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                cpu_exec_q, cpu_exec_d;
  logic                pc_wen_q, pc_wen_d;
  logic                mem_sel_q, mem_sel_d;
  logic                mem_val_q, mem_val_d;
  logic                mem_wen_q, mem_wen_d;
  logic                led_ready_q, led_ready_d;
  logic                led_inwait_q, led_inwait_d;
  logic                bkpt_hit;

  assign btn_raw = {btn_enter_i, btn_stop_i, btn_run_i, btn_step_i,
                    btn_look_i, btn_load_i, btn_addr_i};
  // An edge only counts while its lamp is lit.
  assign go = btn_edge_q & lamp_q;

  always_comb begin
    bkpt_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_BKPT; k++) begin
      if (bkpt_en_i[k] && (core_pc_i == bkpt_addr_i[k*ADDR_W +: ADDR_W])) begin
        bkpt_hit = 1'b1;
      end
    end
    bkpt_hit = bkpt_hit & instr_val_i;
  end

  assign cnt_eff = bkpt_hit ? CNT_W'(1) : count_q;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    addr_d       = addr_q;
    disp_d       = disp_q;
    ret_inwait_d = ret_inwait_q;
    is_load_d    = is_load_q;
    led_halt_d   = led_halt_q;
    led_bkpt_d   = led_bkpt_q;
    unique case (state_q)
      S_READY: begin
        if (go[B_RUN]) begin
          state_d    = S_RUN;
          count_d    = CNT_W'(1);
          led_halt_d = 1'b0;
          led_bkpt_d = 1'b0;
        end else if (go[B_STEP]) begin
          state_d    = S_STEP;
          count_d    = (step_cnt_i == '0) ? CNT_W'(1) : step_cnt_i;
          led_halt_d = 1'b0;
          led_bkpt_d = 1'b0;
        end else if (go[B_LOAD] || go[B_LOOK]) begin
          state_d      = S_MEM;
          is_load_d    = go[B_LOAD];
          ret_inwait_d = 1'b0;
        end else if (go[B_ADDR]) begin
          state_d = S_ADDR;
          addr_d  = sw_addr_i;
        end
      end
      S_ADDR: state_d = S_READY;
      S_MEM: begin
        if (mem_rdy_i) begin
          disp_d  = is_load_q ? sw_data_i : mem_rdata_i;
          if (AUTO_INC != 0) addr_d = addr_q + ADDR_W'(1);
          state_d = ret_inwait_q ? S_INWAIT : S_READY;
        end
      end
      S_RUN: begin
        if (core_halt_i) begin
          state_d    = S_READY;
          led_halt_d = 1'b1;
        end else if (bkpt_hit) begin
          state_d    = S_DRAIN;
          count_d    = CNT_W'(1);
          led_bkpt_d = 1'b1;
        end else if (core_inwait_i) begin
          state_d = S_INWAIT;
        end else if (go[B_STOP]) begin
          state_d = S_DRAIN;
          count_d = CNT_W'(1);
        end
      end
      S_STEP: begin
        state_d = S_DRAIN;
        count_d = cnt_eff;
        if (bkpt_hit) led_bkpt_d = 1'b1;
      end
      S_DRAIN: begin
        count_d = cnt_eff;
        if (core_halt_i) begin
          state_d    = S_READY;
          led_halt_d = 1'b1;
        end else begin
          if (bkpt_hit) led_bkpt_d = 1'b1;
          if (core_inwait_i) begin
            state_d = S_INWAIT;
          end else if (core_idle_i) begin
            if (cnt_eff > CNT_W'(1)) begin
              state_d = S_STEP;
              count_d = cnt_eff - CNT_W'(1);
            end else begin
              state_d = S_READY;
            end
          end
        end
      end
      S_INWAIT: begin
        if (go[B_ENTER]) begin
          state_d = S_READY;
        end else if (go[B_LOAD] || go[B_LOOK]) begin
          state_d      = S_MEM;
          is_load_d    = go[B_LOAD];
          ret_inwait_d = 1'b1;
        end
      end
      default: state_d = S_READY;
    endcase
    // Retire display wins over a LOAD/LOOK completing in the same cycle.
    if (instr_val_i) disp_d = instr_data_i;
  end

  // Registered outputs decoded from the next state
  always_comb begin
    lamp_d       = '0;
    core_rst_n_d = 1'b1;
    cpu_exec_d   = 1'b0;
    pc_wen_d     = 1'b0;
    mem_sel_d    = 1'b0;
    mem_val_d    = 1'b0;
    mem_wen_d    = 1'b0;
    led_ready_d  = 1'b0;
    led_inwait_d = 1'b0;
    unique case (state_d)
      S_READY: begin
        lamp_d       = LAMP_READY;
        core_rst_n_d = 1'b0;
        mem_sel_d    = 1'b1;
        led_ready_d  = 1'b1;
      end
      S_ADDR: begin
        core_rst_n_d = 1'b0;
        pc_wen_d     = 1'b1;
        mem_sel_d    = 1'b1;
      end
      S_MEM: begin
        core_rst_n_d = ret_inwait_d;
        mem_sel_d    = 1'b1;
        mem_val_d    = 1'b1;
        mem_wen_d    = is_load_d;
      end
      S_RUN: begin
        lamp_d     = LAMP_RUN;
        cpu_exec_d = 1'b1;
      end
      S_STEP:  cpu_exec_d = 1'b1;
      S_DRAIN: cpu_exec_d = 1'b0;
      S_INWAIT: begin
        lamp_d       = LAMP_INWAIT;
        led_inwait_d = 1'b1;
      end
      default: core_rst_n_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= S_READY;
      count_q      <= '0;
      addr_q       <= '0;
      disp_q       <= '0;
      ret_inwait_q <= 1'b0;
      is_load_q    <= 1'b0;
      led_halt_q   <= 1'b0;
      led_bkpt_q   <= 1'b0;
      btn_prev_q   <= '0;
      btn_edge_q   <= '0;
      lamp_q       <= LAMP_READY;
      core_rst_n_q <= 1'b0;
      cpu_exec_q   <= 1'b0;
      pc_wen_q     <= 1'b0;
      mem_sel_q    <= 1'b1;
      mem_val_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      led_ready_q  <= 1'b1;
      led_inwait_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      disp_q       <= disp_d;
      ret_inwait_q <= ret_inwait_d;
      is_load_q    <= is_load_d;
      led_halt_q   <= led_halt_d;
      led_bkpt_q   <= led_bkpt_d;
      btn_prev_q   <= btn_raw;
      btn_edge_q   <= btn_raw & ~btn_prev_q;
      lamp_q       <= lamp_d;
      core_rst_n_q <= core_rst_n_d;
      cpu_exec_q   <= cpu_exec_d;
      pc_wen_q     <= pc_wen_d;
      mem_sel_q    <= mem_sel_d;
      mem_val_q    <= mem_val_d;
      mem_wen_q    <= mem_wen_d;
      led_ready_q  <= led_ready_d;
      led_inwait_q <= led_inwait_d;
    end
  end

  assign {btn_enter_o, btn_stop_o, btn_run_o, btn_step_o,
          btn_look_o, btn_load_o, btn_addr_o} = lamp_q;
  assign led_ready_o  = led_ready_q;
  assign led_inwait_o = led_inwait_q;
  assign led_halt_o   = led_halt_q;
  assign led_bkpt_o   = led_bkpt_q;
  assign core_rst_no  = core_rst_n_q;
  assign cpu_exec_o   = cpu_exec_q;
  assign pc_wen_o     = pc_wen_q;
  assign pc_o         = sw_addr_i;
  assign mem_sel_o    = mem_sel_q;
  assign mem_val_o    = mem_val_q;
  assign mem_wen_o    = mem_wen_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = sw_data_i;
  assign disp_data_o  = disp_q;

endmodule

// File: tb/tb_panel_seq.sv
// Bench for panel_seq: memory and core models, scoreboarded LOAD/LOOK traffic,
// step/run/breakpoint/halt/inwait scenarios and mid-operation reset.
module tb_panel_seq;
  localparam int B_ADDR = 0, B_LOAD = 1, B_LOOK = 2, B_STEP = 3, B_RUN = 4, B_STOP = 5, B_ENTER = 6;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]  btn = '0;
  logic [6:0]  lamps;
  logic        led_ready_o, led_inwait_o, led_halt_o, led_bkpt_o;
  logic [7:0]  sw_addr = '0;
  logic [15:0] sw_data = '0;
  logic [7:0]  step_cnt = 8'd1;
  logic [1:0]  bkpt_en = '0;
  logic [15:0] bkpt_addr = '0;
  logic        core_rst_no, cpu_exec_o, pc_wen_o;
  logic [7:0]  pc_o;
  logic        mem_sel_o, mem_val_o, mem_wen_o, mem_rdy;
  logic [7:0]  mem_addr_o;
  logic [15:0] mem_wdata_o, mem_rdata, disp_data_o;

  // core model state
  logic [7:0]  c_pc;
  logic        c_busy, c_ret, c_halt, c_inwait;
  int          c_cnt;
  logic [7:0]  halt_pc = 8'h18;
  logic [7:0]  wait_pc = 8'hF0;
  logic        core_idle;
  assign core_idle = !c_busy && !c_ret;

  // memory model
  logic [15:0] mem [256];
  int          mem_lat = 1;
  int          mem_cnt;
  assign mem_rdy   = mem_val_o && (mem_cnt + 1 == mem_lat);
  assign mem_rdata = mem[mem_addr_o];

  panel_seq dut (
    .clk_i(clk), .arst_ni(arst_n),
    .btn_addr_i(btn[0]), .btn_load_i(btn[1]), .btn_look_i(btn[2]), .btn_step_i(btn[3]),
    .btn_run_i(btn[4]), .btn_stop_i(btn[5]), .btn_enter_i(btn[6]),
    .btn_addr_o(lamps[0]), .btn_load_o(lamps[1]), .btn_look_o(lamps[2]), .btn_step_o(lamps[3]),
    .btn_run_o(lamps[4]), .btn_stop_o(lamps[5]), .btn_enter_o(lamps[6]),
    .led_ready_o(led_ready_o), .led_inwait_o(led_inwait_o),
    .led_halt_o(led_halt_o), .led_bkpt_o(led_bkpt_o),
    .sw_addr_i(sw_addr), .sw_data_i(sw_data), .step_cnt_i(step_cnt),
    .bkpt_en_i(bkpt_en), .bkpt_addr_i(bkpt_addr),
    .core_rst_no(core_rst_no), .cpu_exec_o(cpu_exec_o), .pc_wen_o(pc_wen_o), .pc_o(pc_o),
    .core_pc_i(c_pc), .core_idle_i(core_idle), .core_halt_i(c_halt), .core_inwait_i(c_inwait),
    .instr_val_i(c_ret), .instr_data_i({8'hA5, c_pc}),
    .mem_sel_o(mem_sel_o), .mem_val_o(mem_val_o), .mem_wen_o(mem_wen_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata),
    .mem_rdy_i(mem_rdy), .disp_data_o(disp_data_o)
  );

  // Simple core: 2 busy cycles, 1 retire cycle, then pc+1
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      c_pc <= '0; c_busy <= 1'b0; c_ret <= 1'b0; c_halt <= 1'b0; c_inwait <= 1'b0; c_cnt <= 0;
    end else begin
      if (pc_wen_o) c_pc <= pc_o;
      if (!core_rst_no) begin
        c_busy <= 1'b0; c_ret <= 1'b0; c_halt <= 1'b0; c_inwait <= 1'b0;
      end else if (c_ret) begin
        c_ret <= 1'b0;
        c_pc  <= c_pc + 8'd1;
        if (c_pc == halt_pc) c_halt <= 1'b1;
        if (c_pc == wait_pc) c_inwait <= 1'b1;
      end else if (c_busy) begin
        if (c_cnt == 1) begin c_busy <= 1'b0; c_ret <= 1'b1; end
        c_cnt <= c_cnt - 1;
      end else if (cpu_exec_o && !c_halt && !c_inwait) begin
        c_busy <= 1'b1; c_cnt <= 2;
      end
    end
  end

  // Monitors
  logic [24:0] obs_q[$];
  logic [24:0] exp_q[$];
  int obs_rd = 0;
  int exec_cnt = 0, ret_cnt = 0, val_cycles = 0, pcw_cnt = 0;
  logic [7:0] last_ret_pc = '0, last_pc = '0;

  always @(posedge clk) begin
    mem_cnt <= (mem_val_o && !mem_rdy) ? mem_cnt + 1 : 0;
    if (mem_val_o) val_cycles <= val_cycles + 1;
    if (mem_val_o && mem_rdy) begin
      obs_q.push_back({mem_wen_o, mem_addr_o, mem_wen_o ? mem_wdata_o : mem_rdata});
      if (mem_wen_o) mem[mem_addr_o] = mem_wdata_o;
    end
    if (cpu_exec_o) exec_cnt <= exec_cnt + 1;
    if (c_ret) begin ret_cnt <= ret_cnt + 1; last_ret_pc <= c_pc; end
    if (pc_wen_o) begin pcw_cnt <= pcw_cnt + 1; last_pc <= pc_o; end
  end

  int n_tests = 0, n_fail = 0;

  task automatic press(input int b);
    @(negedge clk); btn[b] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); btn[b] = 1'b0;
  endtask

  task automatic wait_ready(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (led_ready_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({led_ready_o, led_inwait_o, led_halt_o, led_bkpt_o} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_leds: got %b expected 1000", {led_ready_o, led_inwait_o, led_halt_o, led_bkpt_o});
    end
    n_tests++;
    if ({core_rst_no, cpu_exec_o, pc_wen_o, mem_val_o, mem_sel_o} !== 5'b00001) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 00001", {core_rst_no, cpu_exec_o, pc_wen_o, mem_val_o, mem_sel_o});
    end
    n_tests++;
    if (lamps !== 7'b0011111 || disp_data_o !== 16'h0 || mem_addr_o !== 8'h0) begin
      n_fail++; $display("FAIL reset_regs: lamps %b disp %h addr %h expected 0011111 0000 00", lamps, disp_data_o, mem_addr_o);
    end
    @(negedge clk); arst_n = 1'b1;
  endtask

  task automatic test_addr(input logic [7:0] a);
    int p0 = pcw_cnt;
    sw_addr = a;
    press(B_ADDR);
    n_tests++;
    if (pcw_cnt - p0 !== 1 || last_pc !== a || mem_addr_o !== a) begin
      n_fail++; $display("FAIL addr: pc_wen %0d pc %h addr %h expected 1 %h %h", pcw_cnt - p0, last_pc, mem_addr_o, a, a);
    end
  endtask

  task automatic test_mem_op(input bit load, input logic [15:0] exp_data, input int lat);
    bit ok;
    int v0;
    logic [7:0] a0 = mem_addr_o;
    logic [24:0] e;
    mem_lat = lat;
    v0 = val_cycles;
    exp_q.push_back({load, a0, exp_data});
    press(load ? B_LOAD : B_LOOK);
    wait_ready(50, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL mem_timeout: READY not reached"); end
    e = exp_q.pop_front();
    n_tests++;
    if (obs_q.size() <= obs_rd) begin
      n_fail++; $display("FAIL mem_txn: no transaction observed, expected %h", e);
    end else begin
      if (obs_q[obs_rd] !== e) begin n_fail++; $display("FAIL mem_txn: got %h expected %h", obs_q[obs_rd], e); end
      obs_rd++;
    end
    n_tests++;
    if (disp_data_o !== exp_data || mem_addr_o !== a0 + 8'd1) begin
      n_fail++; $display("FAIL mem_result: disp %h addr %h expected %h %h", disp_data_o, mem_addr_o, exp_data, a0 + 8'd1);
    end
    n_tests++;
    if (val_cycles - v0 !== lat) begin
      n_fail++; $display("FAIL mem_val_hold: got %0d expected %0d", val_cycles - v0, lat);
    end
  endtask

  task automatic test_load_x3;
    test_addr(8'h10);
    sw_data = 16'hBEEF;
    repeat (3) test_mem_op(1'b1, 16'hBEEF, 1);
    n_tests++;
    if (mem[8'h10] !== 16'hBEEF || mem[8'h11] !== 16'hBEEF || mem[8'h12] !== 16'hBEEF || mem_addr_o !== 8'h13) begin
      n_fail++; $display("FAIL load_mem: %h %h %h addr %h expected beef x3 addr 13", mem[8'h10], mem[8'h11], mem[8'h12], mem_addr_o);
    end
  endtask

  task automatic test_look_wrap;
    test_addr(8'hFF);
    test_mem_op(1'b0, 16'h10FF, 3);
  endtask

  task automatic test_step(input logic [7:0] cnt, input int exp_n, input logic [7:0] exp_pc, input bit exp_bk);
    bit ok;
    int e0 = exec_cnt, r0 = ret_cnt;
    step_cnt = cnt;
    press(B_STEP);
    wait_ready(200, ok);
    n_tests++;
    if (!ok || exec_cnt - e0 !== exp_n || ret_cnt - r0 !== exp_n) begin
      n_fail++; $display("FAIL step_%0d: ready %0b exec %0d retire %0d expected 1 %0d %0d", cnt, ok, exec_cnt - e0, ret_cnt - r0, exp_n, exp_n);
    end
    n_tests++;
    if (last_ret_pc !== exp_pc || disp_data_o !== {8'hA5, exp_pc} || led_bkpt_o !== exp_bk) begin
      n_fail++; $display("FAIL step_%0d_state: pc %h disp %h bkpt %b expected %h a5%h %b", cnt, last_ret_pc, disp_data_o, led_bkpt_o, exp_pc, exp_pc, exp_bk);
    end
  endtask

  task automatic test_run(input logic [1:0] en, input int exp_n, input logic [7:0] exp_pc, input logic [1:0] exp_hb);
    bit ok;
    int r0;
    bkpt_en = en;
    test_addr(8'h10);
    r0 = ret_cnt;
    press(B_RUN);
    wait_ready(300, ok);
    n_tests++;
    if (!ok || ret_cnt - r0 !== exp_n || last_ret_pc !== exp_pc) begin
      n_fail++; $display("FAIL run_en%b: ready %0b retire %0d pc %h expected 1 %0d %h", en, ok, ret_cnt - r0, last_ret_pc, exp_n, exp_pc);
    end
    n_tests++;
    if ({led_halt_o, led_bkpt_o} !== exp_hb) begin
      n_fail++; $display("FAIL run_en%b_leds: got %b expected %b", en, {led_halt_o, led_bkpt_o}, exp_hb);
    end
    bkpt_en = '0;
  endtask

  task automatic test_halt_stop;
    bit found = 1'b0;
    halt_pc = 8'h12;
    test_addr(8'h10);
    press(B_RUN);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (c_ret && c_pc == 8'h12) begin found = 1'b1; break; end
    end
    btn[B_STOP] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (!found || {led_ready_o, led_halt_o, led_bkpt_o} !== 3'b110) begin
      n_fail++; $display("FAIL halt_stop: found %0b ready/halt/bkpt %b expected 1 110", found, {led_ready_o, led_halt_o, led_bkpt_o});
    end
    btn[B_STOP] = 1'b0;
    halt_pc = 8'h18;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_inwait;
    bit ok;
    bit seen = 1'b0;
    wait_pc = 8'h11;
    test_addr(8'h10);
    press(B_RUN);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (led_inwait_o) begin seen = 1'b1; break; end
    end
    n_tests++;
    if (!seen || lamps !== 7'b1000110 || core_rst_no !== 1'b1 || cpu_exec_o !== 1'b0 || last_ret_pc !== 8'h11) begin
      n_fail++; $display("FAIL inwait: seen %0b lamps %b rst_n %b exec %b pc %h expected 1 1000110 1 0 11", seen, lamps, core_rst_no, cpu_exec_o, last_ret_pc);
    end
    press(B_ENTER);
    wait_ready(20, ok);
    n_tests++;
    if (!ok || led_inwait_o !== 1'b0) begin
      n_fail++; $display("FAIL inwait_enter: ready %0b inwait %b expected 1 0", ok, led_inwait_o);
    end
    wait_pc = 8'hF0;
  endtask

  task automatic test_reset_mid;
    test_addr(8'h05);
    mem_lat = 50;
    press(B_LOAD);
    n_tests++;
    if (mem_val_o !== 1'b1) begin n_fail++; $display("FAIL mid_mem_pre: val %b expected 1", mem_val_o); end
    arst_n = 1'b0; #1;
    n_tests++;
    if ({mem_val_o, mem_sel_o, led_ready_o, core_rst_no, mem_wen_o} !== 5'b01100 || mem_addr_o !== 8'h00) begin
      n_fail++; $display("FAIL mid_mem_rst: val/sel/ready/rst_n/wen %b addr %h expected 01100 00", {mem_val_o, mem_sel_o, led_ready_o, core_rst_no, mem_wen_o}, mem_addr_o);
    end
    @(negedge clk); arst_n = 1'b1;
    mem_lat = 1;
    test_addr(8'h10);
    press(B_RUN);
    repeat (4) @(negedge clk);
    n_tests++;
    if (cpu_exec_o !== 1'b1 || mem_sel_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_run_pre: exec %b sel %b expected 1 0", cpu_exec_o, mem_sel_o);
    end
    arst_n = 1'b0; #1;
    n_tests++;
    if ({cpu_exec_o, core_rst_no, mem_sel_o, led_ready_o, led_halt_o} !== 5'b00110 || lamps !== 7'b0011111 || disp_data_o !== 16'h0) begin
      n_fail++; $display("FAIL mid_run_rst: exec/rst_n/sel/ready/halt %b lamps %b disp %h expected 00110 0011111 0000", {cpu_exec_o, core_rst_no, mem_sel_o, led_ready_o, led_halt_o}, lamps, disp_data_o);
    end
    @(negedge clk); arst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    bkpt_addr = {8'h00, 8'h14};
    test_reset;
    test_load_x3;
    test_look_wrap;
    test_addr(8'h10);
    test_step(8'd3, 3, 8'h12, 1'b0);
    test_step(8'd0, 1, 8'h13, 1'b0);
    test_run(2'b01, 5, 8'h14, 2'b01);
    test_run(2'b00, 9, 8'h18, 2'b10);
    bkpt_addr = {8'h00, 8'h11};
    bkpt_en = 2'b01;
    test_addr(8'h10);
    test_step(8'd5, 2, 8'h11, 1'b1);
    bkpt_en = 2'b00;
    test_halt_stop;
    test_inwait;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
